// File: rtl/imem_access_arbiter.sv
// rtl/imem_access_arbiter.sv - single-port instruction memory arbiter for IF fetch and loader/debug port
//
// Purpose:
//   Serialises accesses from the IF stage (read-only) and the program
//   loader/debug port (word read/write) onto one instruction memory that
//   uses a variable-latency busywait handshake. One access is in flight at
//   a time. Misaligned addresses are answered locally. Memory accesses that
//   stay busy for too long are aborted. Both cases raise a sticky error.
//
// Ports:
//   CLK, RESET                       clock, synchronous active-high reset
//   FETCH_REQ/ADDR -> ACK/INSTR      IF stage read channel, FETCH_STALL while pending
//   LD_REQ/WE/ADDR/WDATA -> ACK/RDATA loader channel
//   MEM_ADDRESS/READ/WRITE/WRITEDATA memory request side
//   MEM_READDATA/BUSYWAIT            memory response side
//   ERR, ERR_CODE                    sticky error flag and first error cause
//
// Optional feature:
//   IMEM_ARB_RR_EN - when defined, simultaneous requests alternate between
//   fetch and loader (fetch wins the first conflict) and LOADER_PRIO is ignored.

module imem_access_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT     = 15,
  parameter bit LOADER_PRIO = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FETCH_REQ,
  input  logic [ADDR_W-1:0] FETCH_ADDR,
  output logic              FETCH_ACK,
  output logic [31:0]       FETCH_INSTR,
  output logic              FETCH_STALL,
  input  logic              LD_REQ,
  input  logic              LD_WE,
  input  logic [ADDR_W-1:0] LD_ADDR,
  input  logic [31:0]       LD_WDATA,
  output logic              LD_ACK,
  output logic [31:0]       LD_RDATA,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [31:0]       MEM_WRITEDATA,
  input  logic [31:0]       MEM_READDATA,
  input  logic              MEM_BUSYWAIT,
  output logic              ERR,
  output logic [1:0]        ERR_CODE
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] E_TIMEOUT  = 2'b01;
  localparam logic [1:0] E_MIS_FET  = 2'b10;
  localparam logic [1:0] E_MIS_LD   = 2'b11;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              owner_q, owner_d;       // 1 = loader owns the current access
  logic [7:0]        cnt_q, cnt_d;
  logic [31:0]       fetch_instr_q, fetch_instr_d;
  logic [31:0]       ld_rdata_q, ld_rdata_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic              grant_ld;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        cnt_inc;

`ifdef IMEM_ARB_RR_EN
  logic last_q, last_d;                      // 1 = loader received the last grant

  always_comb begin
    if (FETCH_REQ && LD_REQ) grant_ld = ~last_q;
    else                     grant_ld = LD_REQ;
  end
`else
  always_comb begin
    if (FETCH_REQ && LD_REQ) grant_ld = LOADER_PRIO;
    else                     grant_ld = LD_REQ;
  end
`endif

  assign sel_addr = grant_ld ? LD_ADDR : FETCH_ADDR;
  assign cnt_inc  = cnt_q + 8'd1;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    fetch_instr_d = fetch_instr_q;
    ld_rdata_d    = ld_rdata_q;
    err_d         = err_q;
    err_code_d    = err_code_q;
`ifdef IMEM_ARB_RR_EN
    last_d        = last_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (FETCH_REQ || LD_REQ) begin
          owner_d = grant_ld;
          addr_d  = sel_addr;
          we_d    = grant_ld & LD_WE;
          wdata_d = grant_ld ? LD_WDATA : 32'd0;
          cnt_d   = 8'd0;
`ifdef IMEM_ARB_RR_EN
          last_d  = grant_ld;
`endif
          if (sel_addr[1:0] != 2'b00) begin
            // Misaligned: never touch memory, answer with zero data next cycle.
            state_d = S_DONE;
            if (grant_ld) ld_rdata_d    = 32'd0;
            else          fetch_instr_d = 32'd0;
            if (!err_q) begin
              err_d      = 1'b1;
              err_code_d = grant_ld ? E_MIS_LD : E_MIS_FET;
            end
          end else begin
            state_d = grant_ld ? S_LOAD : S_FETCH;
          end
        end
      end

      S_FETCH, S_LOAD: begin
        if (!MEM_BUSYWAIT) begin
          // Loader writes leave LD_RDATA untouched; only reads return data.
          if (!owner_q)   fetch_instr_d = MEM_READDATA;
          else if (!we_q) ld_rdata_d    = MEM_READDATA;
          state_d = S_DONE;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          // A stalled fetch is fed a NOP so the pipeline can keep moving.
          if (!owner_q) fetch_instr_d = NOP_INSTR;
          else          ld_rdata_d    = 32'd0;
          cnt_d   = cnt_inc;
          state_d = S_DONE;
          if (!err_q) begin
            err_d      = 1'b1;
            err_code_d = E_TIMEOUT;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= 32'd0;
      owner_q       <= 1'b0;
      cnt_q         <= 8'd0;
      fetch_instr_q <= 32'd0;
      ld_rdata_q    <= 32'd0;
      err_q         <= 1'b0;
      err_code_q    <= 2'b00;
`ifdef IMEM_ARB_RR_EN
      last_q        <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      fetch_instr_q <= fetch_instr_d;
      ld_rdata_q    <= ld_rdata_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
`ifdef IMEM_ARB_RR_EN
      last_q        <= last_d;
`endif
    end
  end

  // Strobes decode from state, so leaving FETCH/LOAD drops them on the next cycle.
  assign MEM_ADDRESS   = addr_q;
  assign MEM_WRITEDATA = wdata_q;
  assign MEM_READ      = (state_q == S_FETCH) || ((state_q == S_LOAD) && !we_q);
  assign MEM_WRITE     = (state_q == S_LOAD) && we_q;

  assign FETCH_ACK     = (state_q == S_DONE) && !owner_q;
  assign LD_ACK        = (state_q == S_DONE) && owner_q;
  assign FETCH_INSTR   = fetch_instr_q;
  assign LD_RDATA      = ld_rdata_q;
  assign FETCH_STALL   = FETCH_REQ & ~FETCH_ACK;

  assign ERR           = err_q;
  assign ERR_CODE      = err_code_q;

endmodule

// File: doc/imem_access_arbiter.md
Name: imem_access_arbiter

Overview:
Shares the single-port instruction memory between two requesters: the pipeline IF stage (read-only fetch) and the program loader/debug port (word writes and reads). Sits between the IF stage/loader and the instruction memory, which presents a variable-latency busywait handshake. Sequences one access at a time through a small FSM, stalls the losing requester, and flags memory timeouts and misaligned addresses.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
TIMEOUT, 15, max cycles MEM_BUSYWAIT may stay high before an access is aborted (1..255)
LOADER_PRIO, 1, 1 = loader wins simultaneous requests; 0 = fetch wins

Ports:
CLK  input  1  system clock, all state on rising edge
RESET  input  1  synchronous, active-high reset
FETCH_REQ  input  1  IF stage read request, held until FETCH_ACK
FETCH_ADDR  input  ADDR_W  fetch byte address (PC)
FETCH_ACK  output  1  one-cycle pulse: FETCH_INSTR valid
FETCH_INSTR  output  32  fetched instruction word
FETCH_STALL  output  1  high while FETCH_REQ is pending and not yet acked
LD_REQ  input  1  loader request, held until LD_ACK
LD_WE  input  1  loader 1 = write, 0 = read
LD_ADDR  input  ADDR_W  loader byte address
LD_WDATA  input  32  loader write data
LD_ACK  output  1  one-cycle pulse: access complete
LD_RDATA  output  32  loader read data, valid with LD_ACK
MEM_ADDRESS  output  ADDR_W  address to instruction memory
MEM_READ  output  1  memory read strobe
MEM_WRITE  output  1  memory write strobe
MEM_WRITEDATA  output  32  memory write data
MEM_READDATA  input  32  memory read data, valid when MEM_BUSYWAIT low
MEM_BUSYWAIT  input  1  memory busy; access completes on first cycle it is low while strobed
ERR  output  1  sticky: timeout or misaligned access since reset
ERR_CODE  output  2  00 none, 01 timeout, 10 misaligned fetch, 11 misaligned loader

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter 0; ERR/ERR_CODE cleared. RESET mid-access drops strobes next cycle, no ACK issued.
- States: IDLE, FETCH, LOAD, DONE.
- IDLE: sample requests. Both high -> LOADER_PRIO picks. Selected request latches address/WE/data into registers, goes to FETCH or LOAD. Neither -> stay.
- Misaligned (addr[1:0] != 0): no memory access; pulse ACK with data 0 next cycle, set ERR, ERR_CODE 10/11; first error wins, ERR_CODE not overwritten until reset.
- FETCH/LOAD: MEM_ADDRESS = latched addr; MEM_READ (or MEM_WRITE for loader write) held high; counter increments each cycle MEM_BUSYWAIT high.
- Completion: first cycle strobe high and MEM_BUSYWAIT low -> capture MEM_READDATA into FETCH_INSTR/LD_RDATA, drop strobes next cycle, go DONE.
- Timeout: counter reaches TIMEOUT -> abort, drop strobes, ACK with data 32'h00000013 (NOP) for fetch or 0 for loader, ERR, ERR_CODE 01.
- DONE: ACK pulses exactly one cycle; return IDLE. Minimum latency request->ACK: 2 cycles (zero-wait memory). Back-to-back: next access starts cycle after DONE.
- Data outputs hold last value between ACKs.
- FETCH_STALL = FETCH_REQ & ~FETCH_ACK (combinational).
- Requester dropping REQ mid-access: access still completes, ACK still pulses.
- Only one of MEM_READ/MEM_WRITE ever high; never both requesters in flight.

Optional Feature:
IMEM_ARB_RR_EN: defined -> LOADER_PRIO ignored; simultaneous requests alternate via a 1-bit last-grant register (reset: last = loader, so fetch wins first conflict). Undefined -> fixed priority per LOADER_PRIO.

Test Plan:
- Zero-wait fetch FETCH_ADDR=0x10, MEM_READDATA=0x002081B3 -> MEM_READ at cycle 1, FETCH_ACK cycle 2 with FETCH_INSTR=0x002081B3, FETCH_STALL high cycles 0-1.
- Loader write LD_ADDR=0x4, LD_WDATA=0x00000093, BUSYWAIT high 3 cycles -> MEM_WRITE held 4 cycles, LD_ACK once, MEM_READ never high.
- Simultaneous FETCH_REQ+LD_REQ, LOADER_PRIO=1 -> loader served first, fetch ACK follows; with IMEM_ARB_RR_EN, two conflicts -> fetch, loader, fetch order.
- BUSYWAIT stuck high, TIMEOUT=15 -> abort after 15 cycles, FETCH_INSTR=0x00000013, ERR=1, ERR_CODE=01.
- Fetch at 0x6 -> no MEM_READ, ACK with 0, ERR_CODE=10; later timeout leaves ERR_CODE=10.
- RESET asserted during LOAD with BUSYWAIT high -> strobes 0 next cycle, no LD_ACK, ERR=0.
